// File: rtl/mul_seq_ctrl_if.sv
// Operand/product handshake bundle for the radix-4 sequential multiplier.
interface mul_seq_ctrl_if #(parameter int WIDTH = 32);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, product, busy);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, product, busy);
endinterface

// File: rtl/mul_seq_ctrl.sv
// Radix-4 iterative unsigned multiplier sequencer: one add-shift per cycle, WIDTH/2 cycles.
// Optional MUL_SEQ_EARLY_TERM_EN: stop once the remaining multiplier bits are zero.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, m_q, hi_q, lo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] prod_q, prod_n;
  logic [WIDTH+1:0]   pp, sum;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic               last;

  // hi stays below a, so hi + 3a < 2^(WIDTH+2): the sum never overflows.
  always_comb begin
    pp = '0;
    case (m_q[1:0])
      2'd0: pp = '0;
      2'd1: pp = {2'b00, a_q};
      2'd2: pp = {1'b0, a_q, 1'b0};
      2'd3: pp = {2'b00, a_q} + {1'b0, a_q, 1'b0};
      default: pp = '0;
    endcase
    sum  = {2'b00, hi_q} + pp;
    hi_n = sum[WIDTH+1:2];
    lo_n = {sum[1:0], lo_q[WIDTH-1:2]};
  end

`ifdef MUL_SEQ_EARLY_TERM_EN
  // Early exit leaves the low product bits at the top of lo; shift them down.
  always_comb begin
    last   = (cnt_q == CNT_W'(WIDTH/2-1)) || (m_q[WIDTH-1:2] == '0);
    prod_n = {hi_n, lo_n} >> (WIDTH - 2*(int'(cnt_q) + 1));
  end
`else
  always_comb begin
    last   = (cnt_q == CNT_W'(WIDTH/2-1));
    prod_n = {hi_n, lo_n};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = BUSY;
      BUSY:    if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state == BUSY);
    bus.out_valid = (state == DONE);
    bus.product   = prod_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_q   <= bus.a;
          m_q   <= bus.b;
          hi_q  <= '0;
          lo_q  <= '0;
          cnt_q <= '0;
        end
        BUSY: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          m_q   <= m_q >> 2;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) prod_q <= prod_n;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl; latencies track MUL_SEQ_EARLY_TERM_EN.
module tb_mul_seq_ctrl;
  localparam int W = 32;
`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam int LAT_BASIC = 2;
  localparam int LAT_ZERO  = 1;
`else
  localparam int LAT_BASIC = 16;
  localparam int LAT_ZERO  = 16;
`endif
  localparam int LAT_FULL = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mul_seq_ctrl_if #(.WIDTH(W)) bus ();
  mul_seq_ctrl #(.WIDTH(W), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.out_valid && lat < 40);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_in_ready"},  bus.in_ready,  1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
  endtask

  initial begin
    int lat;
    int seen;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_product",   bus.product,   0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    // basic 3*4
    issue(32'd3, 32'd4);
    chk("basic_busy", bus.busy, 1);
    chk("basic_in_ready", bus.in_ready, 0);
    wait_done(lat);
    chk("basic_lat", lat, LAT_BASIC);
    chk("basic_prod", bus.product, 64'd12);
    handshake("basic");
    chk("basic_prod_kept", bus.product, 64'd12);

    // reset in the middle of an operation
    issue(32'd5, 32'd7);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_product",   bus.product,   0);
    chk("midrst_in_ready",  bus.in_ready,  1);
    chk("midrst_busy",      bus.busy,      0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);

    // max operands
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    chk("max_lat",  lat, LAT_FULL);
    chk("max_prod", bus.product, 64'hFFFF_FFFE_0000_0001);
    handshake("max");

    // backpressure with an ignored request while DONE
    issue(32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(lat);
    chk("bp_lat",  lat, LAT_FULL);
    chk("bp_prod", bus.product, 64'h0B00_EA4E_242D_2080);
    bus.in_valid = 1'b1;
    bus.a        = 32'd1;
    bus.b        = 32'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_prod",  bus.product,   64'h0B00_EA4E_242D_2080);
      chk("bp_hold_ready", bus.in_ready,  0);
      chk("bp_hold_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    handshake("bp");
    chk("bp_idle_busy", bus.busy, 0);
    chk("bp_prod_kept", bus.product, 64'h0B00_EA4E_242D_2080);

    // zero operands back-to-back, out_ready tied, in_valid held
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 32'hFFFF_FFFF;
    bus.b         = 32'd0;
    step();
    bus.a = 32'd0;
    bus.b = 32'hFFFF_FFFF;
    wait_done(lat);
    chk("zero1_lat",  lat, LAT_ZERO);
    chk("zero1_prod", bus.product, 0);
    step();
    chk("zero1_ret_idle", bus.in_ready, 1);
    step();
    chk("zero2_accepted", bus.busy, 1);
    bus.in_valid = 1'b0;
    wait_done(lat);
    chk("zero2_lat",  lat, LAT_FULL);
    chk("zero2_prod", bus.product, 0);
    step();
    bus.out_ready = 1'b0;
    chk("zero2_ret_idle", bus.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
